// File: rtl/trace_port.sv
// trace_port: captures one {step, pc, instr, watch} record per enabled CPU step and serializes it as 4 words.
// Latency: word0 of a record captured at edge t is valid in the cycle right after t when the port is idle.
// Backpressure: valid/ready stream; data/last hold while stalled; records arriving with the FIFO full are dropped and counted.
//
// Parameter: DEPTH      record FIFO depth, power of two, 2..64 (default 8)
// Ports:     clk_i, rst_i (synchronous, active-high)
//            en_i, pc_i, instr_i, watch_i        capture side, one record per en_i=1 cycle
//            trace_valid_o, trace_ready_i,       word stream towards the consumer
//            trace_data_o, trace_last_o          (last marks word3 of each record)
//            overflow_o, drop_cnt_o              sticky drop flag and saturating drop counter
// Macro:     TRACE_WORD_PC_EN - when defined, word1 carries the instruction index pc_i>>2 instead of pc_i.

module trace_port #(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] watch_i,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef struct packed {
    logic [31:0] step;
    logic [31:0] word1;
    logic [31:0] instr;
    logic [31:0] watch;
  } rec_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   step_q;
  state_t        state;
  logic [1:0]    word_idx;

  logic xfer;
  logic pop;
  logic full;
  logic push;
  logic drop;
  rec_t new_rec;
  rec_t head;
  logic [31:0] cur_word;

  assign xfer = trace_valid_o & trace_ready_i;
  assign pop  = xfer & (word_idx == 2'd3);
  assign full = (count == FULL_CNT);
  // A pop of the head's last word frees a slot on the same edge, so a capture then is not a drop.
  assign push = en_i & (~full | pop);
  assign drop = en_i & full & ~pop;

  always_comb begin
    new_rec.step  = step_q;
`ifdef TRACE_WORD_PC_EN
    new_rec.word1 = {2'b00, pc_i[31:2]};
`else
    new_rec.word1 = pc_i;
`endif
    new_rec.instr = instr_i;
    new_rec.watch = watch_i;
  end

  assign head = mem[rd_ptr];

  always_comb begin
    cur_word = head.step;
    case (word_idx)
      2'd0: cur_word = head.step;
      2'd1: cur_word = head.word1;
      2'd2: cur_word = head.instr;
      2'd3: cur_word = head.watch;
      default: cur_word = head.step;
    endcase
  end

  // Outputs derive from registered state only; data is forced to zero when nothing is presented.
  assign trace_valid_o = (state == SEND);
  assign trace_data_o  = trace_valid_o ? cur_word : 32'd0;
  assign trace_last_o  = trace_valid_o & (word_idx == 2'd3);

  // Record storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      step_q     <= 32'd0;
      overflow_o <= 1'b0;
      drop_cnt_o <= 16'd0;
      state      <= IDLE;
      word_idx   <= 2'd0;
    end else begin
      // Assigned every cycle (adds 0 when idle) so the counter always reflects its own last value.
      step_q <= step_q + {31'd0, en_i};

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) begin
          drop_cnt_o <= drop_cnt_o + 1'b1;
        end
      end

      // Entering SEND on the capture edge itself gives word0 in the very next cycle.
      case (state)
        IDLE: begin
          if (push) begin
            state    <= SEND;
            word_idx <= 2'd0;
          end
        end
        SEND: begin
          if (xfer) begin
            word_idx <= word_idx + 1'b1;
            if (pop && (count == ONE_CNT) && !push) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          word_idx <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/trace_port.md
TRACE_PORT -- requirements
Module: trace_port

Interface
REQ-001 The parameter DEPTH, default 8, SHALL set the record FIFO depth; it SHALL be a power of two, 2..64.
REQ-002 The port clk_i, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-003 The port rst_i, input, 1 bit, SHALL be the reset; it is synchronous and active-high.
REQ-004 The port en_i, input, 1 bit, SHALL be the capture enable; a cycle with en_i=1 is one CPU step.
REQ-005 The port pc_i, input, 32 bits, SHALL carry the current program counter in bytes.
REQ-006 The port instr_i, input, 32 bits, SHALL carry the instruction fetched at pc_i.
REQ-007 The port watch_i, input, 32 bits, SHALL carry the watched register value (e.g. Reg_File[16]).
REQ-008 The port trace_valid_o, output, 1 bit, SHALL indicate that trace_data_o holds a valid word.
REQ-009 The port trace_ready_i, input, 1 bit, SHALL be the consumer accept signal.
REQ-010 The port trace_data_o, output, 32 bits, SHALL carry the current trace word.
REQ-011 The port trace_last_o, output, 1 bit, SHALL mark the final word of a record.
REQ-012 The port overflow_o, output, 1 bit, SHALL be the sticky dropped-record flag.
REQ-013 The port drop_cnt_o, output, 16 bits, SHALL carry the count of dropped records.

Function
REQ-014 On each rising edge with en_i=1, the block SHALL capture the record {step, pc, instr, watch}, where step is the 32-bit step counter value before increment.
REQ-015 The step counter SHALL increment by 1 per en_i=1 cycle and wrap from 0xFFFFFFFF to 0.
REQ-016 A captured record SHALL be serialized as 4 words in this order: word0=step, word1=pc, word2=instr, word3=watch; trace_last_o=1 only on word3.
REQ-017 A word SHALL transfer on an edge with trace_valid_o=1 and trace_ready_i=1.
REQ-018 While trace_valid_o=1 and trace_ready_i=0, trace_data_o and trace_last_o SHALL hold stable, and trace_valid_o SHALL NOT deassert.
REQ-019 The transmit FSM SHALL have the states IDLE and SEND(w), w=0..3.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL go to SEND(0); in SEND(w) on a transfer it SHALL go to SEND(w+1); on a transfer in SEND(3) it SHALL pop the record and go to SEND(0) if further records remain, or to IDLE otherwise.
REQ-021 Latency: a record captured at edge t SHALL present word0 with trace_valid_o=1 no earlier than the cycle after t and no later than 1 cycle after t when the FSM is IDLE.
REQ-022 With trace_ready_i held at 1, the block SHALL sustain 1 word per cycle with no bubbles between back-to-back records.
REQ-023 The FIFO SHALL hold DEPTH records; it is full when DEPTH records are unsent or partially sent.
REQ-024 On a capture while the FIFO is full, the record SHALL be dropped: overflow_o SHALL set and remain set until reset, and drop_cnt_o SHALL increment, saturating at 0xFFFF.
REQ-025 On a simultaneous capture and pop of the last word while full, the capture SHALL be accepted and SHALL NOT count as a drop.
REQ-026 On a capture into an empty FIFO while the FSM is IDLE, the record SHALL be transmitted normally and SHALL NOT bypass the ordering.
REQ-027 Records SHALL be delivered strictly in capture order, with no duplication.

Reset
REQ-028 While rst_i=1 at an edge, the block SHALL clear the FIFO, the step counter, overflow_o and drop_cnt_o, and SHALL put the FSM in IDLE; a capture in the same cycle SHALL be ignored.
REQ-029 After reset, the outputs SHALL be trace_valid_o=0, trace_data_o=0, trace_last_o=0, overflow_o=0 and drop_cnt_o=0.
REQ-030 A reset asserted mid-record SHALL abandon that record; the next transfer after reset SHALL be the word0 of a newly captured record.

Configuration
REQ-031 The macro TRACE_WORD_PC_EN, when defined, SHALL make word1 equal to pc_i>>2 with the top 2 bits zero (the instruction index).
REQ-032 When TRACE_WORD_PC_EN is undefined, word1 SHALL equal pc_i unchanged; no other behaviour SHALL differ.

Verification
REQ-033 Reset, then en_i=1 for 1 cycle with pc=0x8, instr=0x20100001, watch=5, and ready=1 -> the bench SHALL see words 0, 0x8 (or 0x2 with TRACE_WORD_PC_EN), 0x20100001, 5 on consecutive cycles, with last=1 on the 4th word.
REQ-034 3 captures with ready=0 for 20 cycles, then ready=1 -> the bench SHALL see 12 words in order with steps 0,1,2, and data held stable during the stall.
REQ-035 DEPTH=8, ready=0, 10 captures -> the bench SHALL see overflow_o=1 and drop_cnt_o=2; after ready=1, 8 records with steps 0..7 SHALL drain.
REQ-036 FIFO full, and the final word3 of the head record accepted on the same edge as a new capture -> drop_cnt_o SHALL be unchanged and the new record SHALL be delivered last.
REQ-037 rst_i pulsed during SEND(2) -> trace_valid_o SHALL be 0 the next cycle, and the first record after reset SHALL have step=0.
REQ-038 Step counter forced to 0xFFFFFFFF, then 2 captures -> the bench SHALL see steps 0xFFFFFFFF then 0.
